// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// The parity helper returns the parity bit a sender would transmit for the given data.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first data capture for one frame: bit-indexed shift register, bit counter and
// running parity, all driven by enables from the framing FSM.
module rx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_data,
    output logic              o_parity,
    output logic              o_last
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_parity;

    // The counter parks on the last index instead of wrapping; a new start bit clears it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
        end else if (i_clear) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
        end else if (i_shift) begin
            r_data[r_cnt] <= i_bit;
            r_parity      <= r_parity ^ i_bit;
            if (r_cnt != LAST_CNT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_data   = r_data;
    assign o_parity = r_parity;
    assign o_last   = (r_cnt == LAST_CNT);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop framing FSM feeding a one-entry
// valid/ready holding register. The line is sampled on the rising edge of clk.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    rx_state_t r_state;
    rx_state_t w_stateNext;

    logic              w_clear;
    logic              w_shift;
    logic              w_parityCheck;
    logic              w_load;
    logic              w_overrun;
    logic              w_frameErr;
    logic              w_canLoad;
    logic              w_last;
    logic              w_accParity;
    logic [DATA_W-1:0] w_shiftData;

    logic [DATA_W-1:0] r_dout;
    logic              r_doutValid;
    logic              r_parityErr;
    logic              r_parMismatch;
    logic              r_frameErr;
    logic              r_overrun;
    logic              r_busy;

    rx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shiftReg (
        .clk      (clk),
        .clr      (clr),
        .i_clear  (w_clear),
        .i_shift  (w_shift),
        .i_bit    (din),
        .o_data   (w_shiftData),
        .o_parity (w_accParity),
        .o_last   (w_last)
    );

    // A completed byte may load when the holding register is empty or is being drained this edge.
    assign w_canLoad = !r_doutValid || dout_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_clear       = 1'b0;
        w_shift       = 1'b0;
        w_parityCheck = 1'b0;
        w_load        = 1'b0;
        w_overrun     = 1'b0;
        w_frameErr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (din != LINE_IDLE) begin
                    w_clear     = 1'b1;
                    w_stateNext = ST_DATA;
                end
            end
            ST_DATA: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_stateNext = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_parityCheck = 1'b1;
                w_stateNext   = ST_STOP;
            end
            ST_STOP: begin
                if (din == STOP_LEVEL) begin
                    w_load      = w_canLoad;
                    w_overrun   = !w_canLoad;
                    w_stateNext = ST_IDLE;
                end else begin
                    w_frameErr  = 1'b1;
                    w_stateNext = ST_BREAK;
                end
            end
            // A held-low line after a bad stop bit must not be mistaken for a start bit.
            ST_BREAK: begin
                if (din == LINE_IDLE) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dout        <= '0;
            r_doutValid   <= 1'b0;
            r_parityErr   <= 1'b0;
            r_parMismatch <= 1'b0;
            r_frameErr    <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frameErr <= w_frameErr;
            r_overrun  <= w_overrun;
            r_busy     <= (w_stateNext != ST_IDLE);
            if (w_clear) begin
                r_parMismatch <= 1'b0;
            end else if (w_parityCheck) begin
                r_parMismatch <= (din != calc_parity(64'(w_accParity), ODD_PARITY));
            end
            // A load on the same edge as a drain keeps valid high with the new byte.
            if (w_load) begin
                r_dout      <= w_shiftData;
                r_parityErr <= r_parMismatch;
                r_doutValid <= 1'b1;
            end else if (r_doutValid && dout_ready) begin
                r_doutValid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign parity_err = r_parityErr;
    assign frame_err  = r_frameErr;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: frames are described as line bit sequences
// with their expected outcomes, and a byte-level holding-register model predicts outputs.
module tb_serial_frame_rx;

    localparam int DATA_W     = 8;
    localparam bit PARITY_EN  = 1'b1;
    localparam bit ODD_PARITY = 1'b0;

    logic              clk;
    logic              clr;
    logic              din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    serial_frame_rx #(
        .DATA_W     (DATA_W),
        .PARITY_EN  (PARITY_EN),
        .ODD_PARITY (ODD_PARITY)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Per-cycle schedule: line level, ready level, completion event at that edge
    // (0 none, 1 good stop, 2 bad stop), byte/parity outcome and expected busy after the edge.
    bit                lineQ[$];
    bit                readyQ[$];
    int                evQ[$];
    logic [DATA_W-1:0] dataQ[$];
    bit                perrQ[$];
    bit                busyQ[$];

    // Holding register as seen by the consumer.
    bit                mValid = 1'b0;
    logic [DATA_W-1:0] mData  = '0;
    bit                mPerr  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit pickReady(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return bit'(mode);
    endfunction

    task automatic pushCycle(input bit line, input bit rdy, input int ev,
                             input logic [DATA_W-1:0] data, input bit perr, input bit expBusy);
        lineQ.push_back(line);
        readyQ.push_back(rdy);
        evQ.push_back(ev);
        dataQ.push_back(data);
        perrQ.push_back(perr);
        busyQ.push_back(expBusy);
    endtask

    task automatic addIdle(input int n, input int readyMode);
        for (int i = 0; i < n; i++) pushCycle(1'b1, pickReady(readyMode), 0, '0, 1'b0, 1'b0);
    endtask

    // stopReady < 0 means the stop cycle follows readyMode like every other cycle.
    task automatic addFrame(input logic [DATA_W-1:0] data, input bit flipPar, input bit badStop,
                            input int lowExtra, input int gap, input int readyMode, input int stopReady);
        bit refPar;
        bit sentPar;
        bit stopRdy;
        refPar  = (^data) ^ ODD_PARITY;
        sentPar = refPar ^ flipPar;
        addIdle(gap, readyMode);
        pushCycle(1'b0, pickReady(readyMode), 0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DATA_W; i++) pushCycle(data[i], pickReady(readyMode), 0, '0, 1'b0, 1'b1);
        if (PARITY_EN) pushCycle(sentPar, pickReady(readyMode), 0, '0, 1'b0, 1'b1);
        stopRdy = (stopReady < 0) ? pickReady(readyMode) : bit'(stopReady);
        if (badStop) begin
            pushCycle(1'b0, stopRdy, 2, data, 1'b0, 1'b1);
            for (int i = 0; i < lowExtra; i++) pushCycle(1'b0, pickReady(readyMode), 0, '0, 1'b0, 1'b1);
            pushCycle(1'b1, pickReady(readyMode), 0, '0, 1'b0, 1'b0);
        end else begin
            pushCycle(1'b1, stopRdy, 1, data, PARITY_EN && (sentPar != refPar), 1'b0);
        end
    endtask

    // Drive each scheduled cycle on the falling edge, advance the model at the rising edge,
    // then compare shortly after it.
    task automatic applyStimulus();
        while (lineQ.size() > 0) begin
            bit                lineBit;
            bit                rdy;
            int                ev;
            logic [DATA_W-1:0] evData;
            bit                evPerr;
            bit                expBusy;
            bit                xfer;
            bit                expFe;
            bit                expOv;
            lineBit = lineQ.pop_front();
            rdy     = readyQ.pop_front();
            ev      = evQ.pop_front();
            evData  = dataQ.pop_front();
            evPerr  = perrQ.pop_front();
            expBusy = busyQ.pop_front();
            @(negedge clk);
            din        = lineBit;
            dout_ready = rdy;
            @(posedge clk);
            xfer  = mValid && rdy;
            expFe = 1'b0;
            expOv = 1'b0;
            if (xfer) mValid = 1'b0;
            if (ev == 1) begin
                if (!mValid) begin
                    mValid = 1'b1;
                    mData  = evData;
                    mPerr  = evPerr;
                end else begin
                    expOv = 1'b1;
                end
            end else if (ev == 2) begin
                expFe = 1'b1;
            end
            #1;
            checkOutput("dout_valid", 32'(dout_valid), 32'(mValid));
            checkOutput("frame_err", 32'(frame_err), 32'(expFe));
            checkOutput("overrun", 32'(overrun), 32'(expOv));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            if (mValid) begin
                checkOutput("dout", 32'(dout), 32'(mData));
                checkOutput("parity_err", 32'(parity_err), 32'(mPerr));
            end
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, " dout"}, 32'(dout), 32'h0);
        checkOutput({phase, " dout_valid"}, 32'(dout_valid), 32'h0);
        checkOutput({phase, " parity_err"}, 32'(parity_err), 32'h0);
        checkOutput({phase, " frame_err"}, 32'(frame_err), 32'h0);
        checkOutput({phase, " overrun"}, 32'(overrun), 32'h0);
        checkOutput({phase, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        clr        = 1'b1;
        din        = 1'b1;
        dout_ready = 1'b0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        $display("[TB] directed frames");
        addIdle(2, 1);
        addFrame(8'hA5, 1'b0, 1'b0, 0, 1, 1, -1);
        addFrame(8'h3C, 1'b1, 1'b0, 0, 2, 1, -1);
        addFrame(8'h81, 1'b0, 1'b1, 5, 2, 1, -1);
        addFrame(8'h55, 1'b0, 1'b0, 0, 0, 1, -1);
        addIdle(2, 1);
        addFrame(8'h11, 1'b0, 1'b0, 0, 0, 0, -1);
        addFrame(8'h22, 1'b0, 1'b0, 0, 0, 0, -1);
        addIdle(3, 0);
        addIdle(3, 1);
        addFrame(8'h66, 1'b0, 1'b0, 0, 1, 0, -1);
        addFrame(8'h77, 1'b0, 1'b0, 0, 1, 0, 1);
        addIdle(3, 1);
        applyStimulus();

        $display("[TB] random frames");
        for (int k = 0; k < 40; k++) begin
            addFrame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), -1);
        end
        addIdle(4, 1);
        applyStimulus();

        $display("[TB] reset mid-frame");
        addFrame(8'h99, 1'b0, 1'b0, 0, 1, 0, -1);
        pushCycle(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pushCycle(((8'hF0 >> i) & 8'h01) != 0, 1'b0, 0, '0, 1'b0, 1'b1);
        applyStimulus();
        #2;
        clr = 1'b1;
        #1;
        checkAllZero("clr");
        mValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr        = 1'b0;
        din        = 1'b1;
        dout_ready = 1'b1;
        addFrame(8'h0F, 1'b0, 1'b0, 0, 1, 1, -1);
        addIdle(3, 1);
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
